spi_sram: RTL and testbench
===========================

# spi_sram

Serial SRAM master that turns single-beat CPU memory requests into SPI READ/WRITE transactions to an external 23LC1024-class device. Sits between the memory subsystem's address decode and the `so`/`si`/`sclk`/`sram_ce` pads. Handles byte, halfword and word accesses in little-endian order. Reports completion with a `busy`/`valid` handshake matching what the CPU control FSM already consumes.

## Interface
Parameters:
- `HALF_PERIOD`, default 1: `clk` cycles per `sclk` half-period, ≥1.
- `ADDR_BITS`, default 24: address bits shifted out after the command.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read. Sampled with `ce`.
- `size`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word. Sampled with `ce`.
- `addr`  in  ADDR_BITS  byte address. Sampled with `ce`.
- `wdata`  in  32  write data, byte 0 = bits [7:0]. Sampled with `ce`.
- `rdata`  out  32  read data, zero-extended. Held until the next read completes.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `valid`  out  1  one-cycle pulse when the transaction is complete.
- `sclk`  out  1  SPI clock, mode 0, idles low.
- `si`  out  1  MOSI.
- `so`  in  1  MISO.
- `sram_ce`  out  1  chip select, active-low.

## Operation
- FSM states: IDLE → SELECT → SHIFT → DESELECT → DONE → IDLE.
- **IDLE**
  - `sram_ce`=1, `sclk`=0, `si`=0.
  - On `ce`=1, latch `we`, `size`, `addr`, `wdata`.
  - Build the shift sequence and go to SELECT.
- **Shift sequence**, MSB-first within each field:
  - Command byte: 0x02 for write, 0x03 for read.
  - Then `addr`.
  - Then N data bytes, with N = 1/2/4 from `size`.
  - Data bytes go in order byte0, byte1, …, so the device's sequential mode stores them at `addr`, `addr`+1, ….
- **SELECT**
  - One cycle with `sram_ce`=0.
  - `si` presents the first bit.
- **SHIFT**
  - Total bits B = 8 + ADDR_BITS + 8N.
  - Each bit takes 2·HALF_PERIOD cycles: `sclk` low for HALF_PERIOD, then high for HALF_PERIOD.
  - `si` changes only while `sclk` is low, at the start of each bit.
  - On a read, `so` is sampled on the `sclk` rising edge during data bits only.
  - Received bits are assembled MSB-first per byte into `rdata` byte lanes 0..N-1.
  - Unused lanes of `rdata` are 0.
  - After the last bit's high phase, `sclk` returns to 0 and the FSM goes to DESELECT.
- **DESELECT**
  - One cycle with `sram_ce`=1 and `sclk`=0.
  - `rdata` updates at the end of this cycle on reads.
  - `rdata` is unchanged on writes.
- **DONE**
  - `valid`=1 and `busy`=0 for one cycle.
  - The FSM then returns to IDLE.
- **Boundary rules**
  - `ce` while `busy` is ignored; the request is not queued.
  - `ce` in the DONE cycle is also ignored.
  - Address wrap inside the device is the device's concern; the block never increments `addr`.
  - `size`=11 behaves exactly like 10.
- **Reset**, any state including mid-SHIFT: at the next edge the FSM goes to IDLE with these output values:
  - `sram_ce`=1, `sclk`=0, `si`=0
  - `busy`=0, `valid`=0
  - `rdata`=0
- The aborted transaction is dropped with no `valid` pulse.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: `ce` is accepted at edge 0.
  - `busy` rises after edge 0.
  - `valid` is high in cycle 2 + 2·HALF_PERIOD·B + 1, counting cycle 1 as SELECT.
  - `sram_ce` is low for exactly 1 + 2·HALF_PERIOD·B cycles.
- With HALF_PERIOD=1 and ADDR_BITS=24, `valid` comes B·2+2 cycles after acceptance:
  - word (B=64): 130 cycles
  - halfword (B=48): 98 cycles
  - byte (B=40): 82 cycles
- Back-to-back requests: the earliest next acceptance is the cycle after DONE. That gives ≥1 cycle of `sram_ce` high, plus DONE, between transactions.

## Test plan
- Word write: `addr`=0x000100, `wdata`=0xDEADBEEF, HALF_PERIOD=1.
  - `si` stream must be 0x02, 0x000100, EF, BE, AD, DE.
  - `sram_ce` low for 129 cycles.
  - `valid` pulses once, 130 cycles after acceptance.
- Word read from the SRAM model at 0x000100 returning bytes EF BE AD DE.
  - Command 0x03.
  - `rdata`=0xDEADBEEF at the `valid` pulse.
  - `rdata` unchanged afterwards until the next read.
- Byte read at 0x000103, model byte 0x80.
  - `rdata`=0x00000080.
  - `valid` 82 cycles after acceptance.
- `ce` pulsed repeatedly during a halfword write.
  - Exactly one `sram_ce` low window and one `valid` pulse.
- `reset` asserted at cycle 40 of a word write.
  - Next cycle: `sram_ce`=1, `sclk`=0, `busy`=0.
  - No `valid` pulse.
  - A following read works normally.
- HALF_PERIOD=3, word read.
  - `sclk` period is 6 cycles.
  - `valid` 2 + 6·64 = 386 cycles after acceptance.

Source files
------------

// File: rtl/spi_sram.sv
// SPI master for a 23LC1024-class serial SRAM. Each CPU byte/halfword/word request
// becomes one READ (0x03) or WRITE (0x02) transaction, with data in little-endian byte order.
module spi_sram #(
    parameter int HALF_PERIOD = 1,
    parameter int ADDR_BITS   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 valid,
    output logic                 sclk,
    output logic                 si,
    input  logic                 so,
    output logic                 sram_ce
);
    localparam int HDR_BITS = 8 + ADDR_BITS;
    localparam int MAX_BITS = HDR_BITS + 32;
    localparam int CW       = $clog2(MAX_BITS + 1);
    localparam int PW       = $clog2(2 * HALF_PERIOD + 1);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DESELECT, DONE} state_t;

    state_t              state_q;
    logic [MAX_BITS-1:0] shift_q;
    logic [CW-1:0]       bitIdx_q;
    logic [CW-1:0]       lastBit_q;
    logic [PW-1:0]       phase_q;
    logic [31:0]         rx_q;
    logic [31:0]         rdata_q;
    logic                we_q;
    logic                busy_q;
    logic                valid_q;
    logic                sclk_q;
    logic                si_q;
    logic                sramCe_q;

    logic [MAX_BITS-1:0] load_d;
    logic [CW-1:0]       lastBit_d;
    logic [4:0]          dataBit_d;
    logic [4:0]          rxIdx_d;

    // Byte 0 is shifted first so the device's sequential mode stores it at the lowest address.
    always_comb begin
        load_d = {(we ? 8'h02 : 8'h03), addr,
                  (we ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0)};
        case (size)
            2'b00:   lastBit_d = CW'(HDR_BITS + 7);
            2'b01:   lastBit_d = CW'(HDR_BITS + 15);
            default: lastBit_d = CW'(HDR_BITS + 31);
        endcase
        dataBit_d = 5'(bitIdx_q - CW'(HDR_BITS));
        rxIdx_d   = {dataBit_d[4:3], ~dataBit_d[2:0]};
    end

    // Each bit spends HALF_PERIOD cycles with sclk low, then HALF_PERIOD with sclk high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitIdx_q  <= '0;
            lastBit_q <= '0;
            phase_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            sclk_q    <= 1'b0;
            si_q      <= 1'b0;
            sramCe_q  <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ce) begin
                        we_q      <= we;
                        shift_q   <= load_d;
                        lastBit_q <= lastBit_d;
                        bitIdx_q  <= '0;
                        phase_q   <= '0;
                        rx_q      <= '0;
                        si_q      <= load_d[MAX_BITS-1];
                        sramCe_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SELECT;
                    end
                end
                SELECT: begin
                    sclk_q  <= 1'b0;
                    phase_q <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (phase_q == PW'(HALF_PERIOD - 1)) begin
                        sclk_q <= 1'b1;
                        if (!we_q && bitIdx_q >= CW'(HDR_BITS))
                            rx_q[rxIdx_d] <= so;
                    end
                    if (phase_q == PW'(2 * HALF_PERIOD - 1)) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b0;
                        if (bitIdx_q == lastBit_q) begin
                            si_q     <= 1'b0;
                            sramCe_q <= 1'b1;
                            state_q  <= DESELECT;
                        end else begin
                            bitIdx_q <= bitIdx_q + CW'(1);
                            shift_q  <= shift_q << 1;
                            si_q     <= shift_q[MAX_BITS-2];
                        end
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                DESELECT: begin
                    if (!we_q)
                        rdata_q <= rx_q;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign sclk    = sclk_q;
    assign si      = si_q;
    assign sram_ce = sramCe_q;
endmodule

// File: tb/tb_spi_sram.sv
// Directed bench for spi_sram: instance 0 runs HALF_PERIOD=1, instance 1 runs HALF_PERIOD=3,
// each against a small behavioural serial SRAM that records the MOSI stream and answers reads.
module tb_spi_sram;
    logic clk = 1'b0;
    logic reset;
    logic [1:0]       ce;
    logic [1:0]       we;
    logic [1:0][1:0]  size;
    logic [1:0][23:0] addr;
    logic [1:0][31:0] wdata;
    wire  [1:0][31:0] rdata;
    wire  [1:0]       busy;
    wire  [1:0]       valid;
    wire  [1:0]       sclk;
    wire  [1:0]       si;
    wire  [1:0]       so;
    wire  [1:0]       sramCe;
    wire  [1:0][95:0] stream;
    wire  [1:0][7:0]  bitCount;
    logic [7:0]       mem [0:1023];
    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    spi_sram #(.HALF_PERIOD(1), .ADDR_BITS(24)) dut (
        .clk(clk), .reset(reset), .ce(ce[0]), .we(we[0]), .size(size[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .valid(valid[0]), .sclk(sclk[0]),
        .si(si[0]), .so(so[0]), .sram_ce(sramCe[0])
    );

    spi_sram #(.HALF_PERIOD(3), .ADDR_BITS(24)) dut3 (
        .clk(clk), .reset(reset), .ce(ce[1]), .we(we[1]), .size(size[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .valid(valid[1]), .sclk(sclk[1]),
        .si(si[1]), .so(so[1]), .sram_ce(sramCe[1])
    );

    // Device model: captures MOSI on sclk rise, drives MISO on sclk fall for the next bit.
    for (genvar g = 0; g < 2; g++) begin : model
        logic [95:0] rxStream = '0;
        int          bitCnt = 0;
        logic [23:0] mAddr = '0;
        logic        soR = 1'b0;
        logic        prevCe = 1'b1;
        logic        prevSclk = 1'b0;
        logic [7:0]  curByte;
        int          j;
        assign so[g]       = soR;
        assign stream[g]   = rxStream;
        assign bitCount[g] = 8'(bitCnt);
        always @(sclk[g] or sramCe[g]) begin
            if (sramCe[g] === 1'b0 && prevCe === 1'b1) begin
                bitCnt   = 0;
                rxStream = '0;
                soR      = 1'b0;
            end
            if (sclk[g] === 1'b1 && prevSclk === 1'b0) begin
                rxStream = {rxStream[94:0], si[g]};
                bitCnt   = bitCnt + 1;
                if (bitCnt == 32) mAddr = rxStream[23:0];
            end else if (sclk[g] === 1'b0 && prevSclk === 1'b1) begin
                if (bitCnt >= 32) begin
                    j       = bitCnt - 32;
                    curByte = mem[10'(mAddr + 24'(j / 8))];
                    soR     = curByte[7 - (j % 8)];
                end else begin
                    soR = 1'b0;
                end
            end
            prevCe   = sramCe[g];
            prevSclk = sclk[g];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Issues one request and observes the DUT once per cycle (k = edges after acceptance).
    task automatic runTxn(input int g, input logic isWrite, input logic [1:0] sz,
                          input logic [23:0] a, input logic [31:0] wd, input int maxCyc,
                          input bit pulseCe, input int resetAt,
                          output int validLat, output int ceLow, output int windows,
                          output int validCnt, output logic [31:0] rdAtValid,
                          output logic busyAtStart, output int rise1, output int rise2,
                          output logic [3:0] rstSnap);
        logic prevCe;
        logic prevSclk;
        validLat = -1; ceLow = 0; windows = 0; validCnt = 0; rdAtValid = '0;
        busyAtStart = 1'b0; rise1 = -1; rise2 = -1; rstSnap = '0;
        @(negedge clk);
        ce[g] = 1'b1; we[g] = isWrite; size[g] = sz; addr[g] = a; wdata[g] = wd;
        prevCe = 1'b1;
        prevSclk = 1'b0;
        @(posedge clk);
        for (int k = 0; k < maxCyc; k++) begin
            @(negedge clk);
            if (sramCe[g] === 1'b0) begin
                ceLow++;
                if (prevCe === 1'b1) windows++;
            end
            if (valid[g] === 1'b1) begin
                validCnt++;
                if (validLat < 0) begin
                    validLat  = k;
                    rdAtValid = rdata[g];
                end
            end
            if (sclk[g] === 1'b1 && prevSclk === 1'b0) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            if (k == 0) busyAtStart = busy[g];
            if (k == resetAt) begin
                rstSnap = {sramCe[g], sclk[g], busy[g], valid[g]};
                reset = 1'b0;
            end
            prevCe = sramCe[g];
            prevSclk = sclk[g];
            ce[g] = pulseCe && (k < 80) && (k % 2 == 0);
            if (k == resetAt - 1) reset = 1'b1;
        end
        ce[g] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = '0; we = '0; size = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (sramCe[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_sram_ce: got %b expected 1", sramCe[0]); end
        testsRun++;
        if (sclk[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk[0]); end
        testsRun++;
        if (si[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_si: got %b expected 0", si[0]); end
        testsRun++;
        if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy_valid: got %b%b expected 00", busy[0], valid[0]); end
        testsRun++;
        if (rdata[0] !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata[0]); end
        testsRun++;
        if (sramCe[1] !== 1'b1 || sclk[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dut3: got ce=%b sclk=%b expected ce=1 sclk=0", sramCe[1], sclk[1]); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_write();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(0, 1'b1, 2'b10, 24'h000100, 32'hDEADBEEF, 140, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (stream[0][63:0] !== 64'h02000100_EFBEADDE) begin testsFailed++; $display("[TB] FAIL word_write_stream: got %h expected 02000100efbeadde", stream[0][63:0]); end
        testsRun++;
        if (bitCount[0] !== 8'd64) begin testsFailed++; $display("[TB] FAIL word_write_bits: got %0d expected 64", bitCount[0]); end
        testsRun++;
        if (low !== 129) begin testsFailed++; $display("[TB] FAIL word_write_ce_low: got %0d expected 129", low); end
        testsRun++;
        if (lat !== 130 || cnt !== 1) begin testsFailed++; $display("[TB] FAIL word_write_valid: got lat=%0d count=%0d expected lat=130 count=1", lat, cnt); end
        testsRun++;
        if (bs !== 1'b1) begin testsFailed++; $display("[TB] FAIL word_write_busy: got %b expected 1", bs); end
    endtask

    task automatic test_word_read();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(0, 1'b0, 2'b10, 24'h000100, 32'h0, 140, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (stream[0][63:32] !== 32'h03000100) begin testsFailed++; $display("[TB] FAIL word_read_header: got %h expected 03000100", stream[0][63:32]); end
        testsRun++;
        if (rd !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL word_read_rdata: got %h expected deadbeef", rd); end
        testsRun++;
        if (lat !== 130) begin testsFailed++; $display("[TB] FAIL word_read_latency: got %0d expected 130", lat); end
        testsRun++;
        if (rdata[0] !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL word_read_hold: got %h expected deadbeef", rdata[0]); end
    endtask

    task automatic test_sizes();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(0, 1'b0, 2'b01, 24'h000100, 32'h0, 110, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (rd !== 32'h0000BEEF || lat !== 98) begin testsFailed++; $display("[TB] FAIL half_read: got rdata=%h lat=%0d expected 0000beef lat=98", rd, lat); end
        runTxn(0, 1'b0, 2'b11, 24'h000100, 32'h0, 140, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (rd !== 32'hDEADBEEF || lat !== 130 || low !== 129) begin testsFailed++; $display("[TB] FAIL size11_read: got rdata=%h lat=%0d low=%0d expected deadbeef 130 129", rd, lat, low); end
    endtask

    task automatic test_byte_read();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        mem[10'h103] = 8'h80;
        runTxn(0, 1'b0, 2'b00, 24'h000103, 32'h0, 95, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (stream[0][39:8] !== 32'h03000103) begin testsFailed++; $display("[TB] FAIL byte_read_header: got %h expected 03000103", stream[0][39:8]); end
        testsRun++;
        if (rd !== 32'h00000080) begin testsFailed++; $display("[TB] FAIL byte_read_rdata: got %h expected 00000080", rd); end
        testsRun++;
        if (lat !== 82 || low !== 81) begin testsFailed++; $display("[TB] FAIL byte_read_timing: got lat=%0d low=%0d expected 82 81", lat, low); end
    endtask

    task automatic test_ce_pulsed();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(0, 1'b1, 2'b01, 24'h000200, 32'h1234ABCD, 115, 1'b1, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (win !== 1 || cnt !== 1) begin testsFailed++; $display("[TB] FAIL ce_pulsed_count: got windows=%0d valids=%0d expected 1 1", win, cnt); end
        testsRun++;
        if (lat !== 98) begin testsFailed++; $display("[TB] FAIL ce_pulsed_latency: got %0d expected 98", lat); end
        testsRun++;
        if (stream[0][47:0] !== 48'h02000200_CDAB) begin testsFailed++; $display("[TB] FAIL ce_pulsed_stream: got %h expected 02000200cdab", stream[0][47:0]); end
        testsRun++;
        if (rdata[0] !== 32'h00000080) begin testsFailed++; $display("[TB] FAIL write_keeps_rdata: got %h expected 00000080", rdata[0]); end
    endtask

    task automatic test_reset_mid();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(0, 1'b1, 2'b10, 24'h000300, 32'h11223344, 160, 1'b0, 40, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (snap !== 4'b1000) begin testsFailed++; $display("[TB] FAIL reset_mid_outputs: got ce,sclk,busy,valid=%b expected 1000", snap); end
        testsRun++;
        if (cnt !== 0) begin testsFailed++; $display("[TB] FAIL reset_mid_no_valid: got %0d pulses expected 0", cnt); end
        testsRun++;
        if (rdata[0] !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_mid_rdata: got %h expected 00000000", rdata[0]); end
        mem[10'h103] = 8'hDE;
        runTxn(0, 1'b0, 2'b10, 24'h000100, 32'h0, 140, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (rd !== 32'hDEADBEEF || lat !== 130) begin testsFailed++; $display("[TB] FAIL read_after_reset: got rdata=%h lat=%0d expected deadbeef 130", rd, lat); end
    endtask

    task automatic test_half_period3();
        int lat, low, win, cnt, r1, r2; logic [31:0] rd; logic bs; logic [3:0] snap;
        runTxn(1, 1'b0, 2'b10, 24'h000100, 32'h0, 400, 1'b0, -1, lat, low, win, cnt, rd, bs, r1, r2, snap);
        testsRun++;
        if (lat !== 386 || cnt !== 1) begin testsFailed++; $display("[TB] FAIL hp3_valid: got lat=%0d count=%0d expected 386 1", lat, cnt); end
        testsRun++;
        if (r1 !== 4 || r2 - r1 !== 6) begin testsFailed++; $display("[TB] FAIL hp3_sclk: got first rise=%0d period=%0d expected 4 6", r1, r2 - r1); end
        testsRun++;
        if (low !== 385) begin testsFailed++; $display("[TB] FAIL hp3_ce_low: got %0d expected 385", low); end
        testsRun++;
        if (rd !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL hp3_rdata: got %h expected deadbeef", rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'hEF;
        mem[10'h101] = 8'hBE;
        mem[10'h102] = 8'hAD;
        mem[10'h103] = 8'hDE;
        test_reset();
        test_word_write();
        test_word_read();
        test_sizes();
        test_byte_read();
        test_ce_pulsed();
        test_reset_mid();
        test_half_period3();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
